uart_echo_top: RTL and testbench
================================

Name: uart_echo_top

Overview:
- Top-level UART loopback. Receives 8N1 serial bytes on `rx` and retransmits each valid byte unchanged on `tx`.
- Contains an input synchronizer, a UART receiver, a 4-entry byte FIFO and a UART transmitter.
- Target is a 50 MHz system clock and 115200 baud.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200).
- FIFO_DEPTH, 4, entries in the RX-to-TX byte buffer (power of two).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- nRst  input  1  reset, synchronous and active-high; logic resets on any rising clk edge where nRst=1.
- rx  input  1  serial data in, idles high.
- tx  output  1  serial data out, idles high.

Behaviour:
- Reset (nRst=1 at a clk edge):
  - tx=1; RX and TX state machines go to IDLE; FIFO is emptied; synchronizer flops are set to 1.
  - Reset mid-frame aborts the frame. No partial byte is stored or sent.
- Synchronizer: `rx` passes through 2 flops before use, giving 2 clocks of latency.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- RX state machine:
  - IDLE: waits for a synchronized 0.
  - START: counts CLKS_PER_BIT/2 clocks, then re-samples. If the sample is 1, the edge was a glitch: return to IDLE. If 0, go to DATA.
  - DATA: samples every CLKS_PER_BIT clocks (bit centre), shifting right into an 8-bit register so bit0 arrives first. After 8 samples go to STOP.
  - STOP: samples after CLKS_PER_BIT clocks. If 1, pulse an internal rx_valid for 1 clock with the byte. If 0 (framing error), discard the byte. Either way return to IDLE on the same clock.
  - Detection of the next start bit is re-enabled immediately after the stop sample. This tolerates back-to-back frames and a sender baud up to ±2% off.
- FIFO:
  - rx_valid writes the byte when not full. When full, the new byte is dropped and FIFO contents are unchanged.
  - Read and write in the same clock are both honoured, including when full (the write succeeds because the read frees a slot).
  - Pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.
- TX state machine:
  - IDLE: tx=1. When the FIFO is non-empty, pop one byte and go to START on the next clock.
  - START: tx=0 for CLKS_PER_BIT clocks.
  - DATA: tx=bit[i] for CLKS_PER_BIT clocks each, i=0..7.
  - STOP: tx=1 for CLKS_PER_BIT clocks, then IDLE. A new frame may begin on the following clock if the FIFO is non-empty (minimum 1 clock of idle between frames).
  - `tx` is driven from a register (glitch-free).
- Latency: the TX start bit falls a fixed number of clocks after the RX start edge. That number is 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2, ±1 clock. It is constant for every frame.
- Bytes are echoed in arrival order. Content is unmodified.

Test Plan:
- Reset: hold nRst=1 for 5 clocks with rx=1, then nRst=0 → tx=1 continuously for 1 ms with no activity.
- Single echo: drive 0xAA at 8700 ns/bit (start, bits 0,1,0,1,0,1,0,1, stop) → one frame on tx decoding to 0xAA, bit period 434 clocks ±1, start edge at the fixed latency.
- Repeated stream: 256 frames of 0xAA separated by 100 µs idle → exactly 256 echoed 0xAA frames, none lost or duplicated, tx idle high between frames.
- Data patterns and burst: 0x00, 0xFF, 0x01, 0x80, then 6 back-to-back frames 0x11..0x16 with no idle gap → first 5 bytes echoed in order. Whether 0x16 is dropped (FIFO overflow) depends on TX drain timing; the bench checks no corruption and order preserved.
- Errors: an 8-clock low glitch on rx, and a frame 0x55 with stop bit=0 → no output frame for either. A following valid 0x3C is echoed correctly.
- Reset mid-operation: assert nRst=1 during the 4th data bit of an echoed frame → tx=1 on the next clock, FIFO empty, no partial byte sent afterwards. The next valid frame is echoed normally.

Source files
------------

// File: rtl/uart_echo_top.sv
// 8N1 UART loopback: 2-flop rx synchronizer -> receiver -> byte FIFO -> transmitter.
// TX start bit trails the RX start edge by 4 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks; a byte arriving to a full FIFO is dropped.
module uart_echo_top #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic nRst,
    input  logic rx,
    output logic tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          r_sync1, r_sync2;
    state_t        r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_vld;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
    logic          w_empty, w_full, w_push, w_pop;

    state_t        r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx;

    always_ff @(posedge clk) begin
        if (nRst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Returning to IDLE on the stop sample lets the next start edge be caught half a bit early.
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_vld   <= 1'b0;
        end else begin
            r_rx_vld <= 1'b0;
            case (r_rx_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == HALF_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_sync2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_rx_cnt == BIT_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_rx_cnt == BIT_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_vld   <= r_sync2;
                        r_rx_state <= S_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = (r_tx_state == S_IDLE) && !w_empty;
    assign w_push  = r_rx_vld && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (nRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_rx_shift;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_tx_shift <= r_mem[r_rd_ptr[AW-1:0]];
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_state <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[1];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= S_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    assign tx = r_tx;
endmodule

// File: tb/tb_uart_echo_top.sv
// Directed bench for uart_echo_top at a shortened bit period; a tx decoder feeds a queue checked after each step.
module tb_uart_echo_top;
    localparam int CPB = 20;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 2;

    logic clk  = 1'b0;
    logic nRst = 1'b1;
    logic rx   = 1'b1;
    logic tx;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    logic [7:0] q_b[$];
    int         q_st[$];
    int         q_rise[$];
    logic       q_ok[$];
    int         rx_st[$];

    uart_echo_top #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .nRst(nRst),
        .rx  (rx),
        .tx  (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame is driven 1 ns after clock edges; start time is the first edge that sees the low level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 rx = 1'b0;
        rx_st.push_back(cyc + 1);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = stop;
        repeat (CPB - 1) @(posedge clk);
        if (!stop) begin
            @(posedge clk); #1 rx = 1'b1;
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && q_b.size() < n; i++) @(negedge clk);
    endtask

    task automatic clear_q();
        q_b.delete(); q_st.delete(); q_rise.delete(); q_ok.delete(); rx_st.delete();
    endtask

    task automatic count_lows(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    initial begin : tx_decoder
        int st, rise;
        logic [7:0] d;
        logic ok, ab;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !nRst) begin
                st = cyc; rise = -1; d = '0; ok = 1'b1; ab = 1'b0;
                for (int k = 1; k < 10 * CPB; k++) begin
                    @(negedge clk);
                    if (nRst) ab = 1'b1;
                    if (rise < 0 && tx === 1'b1) rise = k;
                    if (k % CPB == CPB / 2) begin
                        if (k / CPB == 0)      ok = ok && (tx === 1'b0);
                        else if (k / CPB <= 8) d[k / CPB - 1] = tx;
                        else                   ok = ok && (tx === 1'b1);
                    end
                end
                if (!ab) begin
                    q_b.push_back(d); q_st.push_back(st);
                    q_rise.push_back(rise); q_ok.push_back(ok);
                end
            end
        end
    end

    initial begin
        int lows, errs, lat_errs, lat, lat0, n, w;
        logic [7:0] pat [4];
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h01; pat[3] = 8'h80;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_tx_high", 32'(tx), 32'd1);
        @(posedge clk); #1 nRst = 1'b0;
        count_lows(500, lows);
        check("idle_quiet", 32'(lows), 32'd0);
        check("idle_no_frames", 32'(q_b.size()), 32'd0);

        clear_q();
        send_frame(8'hAA, 1'b1);
        wait_frames(1, 400);
        repeat (20) @(negedge clk);
        check("single_count", 32'(q_b.size()), 32'd1);
        check("single_byte", 32'(q_b[0]), 32'hAA);
        check("single_framing", 32'(q_ok[0]), 32'd1);
        check("single_bit_period", 32'(q_rise[0] >= 2*CPB-1 && q_rise[0] <= 2*CPB+1), 32'd1);
        lat = q_st[0] - rx_st[0];
        check("single_latency", 32'(lat >= LAT-1 && lat <= LAT+1), 32'd1);

        clear_q();
        for (int i = 0; i < 256; i++) begin
            send_frame(8'hAA, 1'b1);
            repeat (30) @(posedge clk);
        end
        wait_frames(256, 1000);
        repeat (250) @(negedge clk);
        check("stream_count", 32'(q_b.size()), 32'd256);
        errs = 0; lat_errs = 0;
        lat0 = (q_st.size() > 0) ? q_st[0] - rx_st[0] : 0;
        for (int i = 0; i < q_b.size() && i < 256; i++) begin
            if (q_b[i] !== 8'hAA || q_ok[i] !== 1'b1) errs++;
            lat = q_st[i] - rx_st[i];
            if (lat < LAT-1 || lat > LAT+1 || lat != lat0) lat_errs++;
        end
        check("stream_data_errs", 32'(errs), 32'd0);
        check("stream_latency_errs", 32'(lat_errs), 32'd0);

        clear_q();
        for (int i = 0; i < 4; i++) begin
            send_frame(pat[i], 1'b1);
            repeat (30) @(posedge clk);
        end
        for (int i = 0; i < 6; i++) send_frame(8'h11 + 8'(i), 1'b1);
        wait_frames(10, 3000);
        repeat (250) @(negedge clk);
        n = q_b.size();
        check("burst_count_range", 32'(n >= 9 && n <= 10), 32'd1);
        for (int i = 0; i < 4; i++) check("pattern_byte", 32'(q_b[i]), 32'(pat[i]));
        for (int i = 0; i < 5; i++) check("burst_byte", 32'(q_b[4+i]), 32'h11 + i);
        if (n == 10) check("burst_last_byte", 32'(q_b[9]), 32'h16);
        errs = 0;
        for (int i = 0; i < n; i++) if (q_ok[i] !== 1'b1) errs++;
        check("burst_framing_errs", 32'(errs), 32'd0);

        clear_q();
        @(posedge clk); #1 rx = 1'b0;
        repeat (8) @(posedge clk);
        #1 rx = 1'b1;
        repeat (60) @(posedge clk);
        send_frame(8'h55, 1'b0);
        repeat (300) @(negedge clk);
        check("error_no_output", 32'(q_b.size()), 32'd0);
        send_frame(8'h3C, 1'b1);
        wait_frames(1, 400);
        repeat (20) @(negedge clk);
        check("recover_count", 32'(q_b.size()), 32'd1);
        check("recover_byte", 32'(q_b[0]), 32'h3C);

        clear_q();
        send_frame(8'hA5, 1'b1);
        w = 0;
        while (tx !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (4*CPB + CPB/2) @(negedge clk);
        check("rst_mid_bit3_low", 32'(tx), 32'd0);
        #1 nRst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_tx_high_next_clk", 32'(tx), 32'd1);
        @(posedge clk); #1 nRst = 1'b0;
        count_lows(20*CPB + 50, lows);
        check("rst_no_partial", 32'(lows), 32'd0);
        check("rst_no_frames", 32'(q_b.size()), 32'd0);
        send_frame(8'hC3, 1'b1);
        wait_frames(1, 400);
        repeat (20) @(negedge clk);
        check("post_rst_count", 32'(q_b.size()), 32'd1);
        check("post_rst_byte", 32'(q_b[0]), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
